conv_kxk_pipe: RTL and testbench

Pipelined, parametrised K×K convolution window engine for the CNN datapath. Each accepted window of K·K pixels is multiplied tap-by-tap against a locally stored kernel and reduced by a fully registered adder tree to one full-precision sum. Kernel coefficients load serially through a dedicated port, so the engine keeps streaming without a wide coefficient bus. It replaces the fixed 5×5/8-bit combinational MAC-plus-tree in per-channel conv slices.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_adder_tree_pipe.sv | 76 +++++++
 rtl/conv_kxk_pipe.sv | 120 ++++++++++++
 tb/tb_conv_kxk_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, helpers and FSM encoding for the conv window engine.
// Build option: define CONV_SIGNED_EN for two's complement pixels/coefficients/sums;
// leave it undefined for the unsigned, zero-extending datapath.
package conv_pkg;

`ifdef CONV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    RUN     = 2'd2
  } conv_state_t;

  // ceil(log2(v)), with clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // full-precision output width for a k x k window of data_w-bit operands
  function automatic int out_w_default(input int data_w, input int k);
    return 2 * data_w + clog2(k * k);
  endfunction

  // operand count at tree level l (level 0 = products)
  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  // operand width at tree level l: one bit of growth per level, capped
  function automatic int lvl_w(input int in_w, input int out_w, input int l);
    return (in_w + l < out_w) ? in_w + l : out_w;
  endfunction

endpackage

// File: rtl/conv_adder_tree_pipe.sv
// conv_adder_tree_pipe: fully registered pairwise reduction of N operands.
// One register per level, clog2(N) levels; an odd trailing operand is carried
// to the next level through a register. Extension follows CONV_SIGNED_EN.
module conv_adder_tree_pipe
  import conv_pkg::*;
#(
  parameter int N     = 25,
  parameter int IN_W  = 16,
  parameter int OUT_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N*IN_W-1:0] in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data
);
  localparam int LV = clog2(N);
  localparam int WL = lvl_w(IN_W, OUT_W, LV);

  logic [LV:1] vld_pipe;

  // valid shift register, one bit per tree level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[LV-1:1], in_valid} ;
  end

  for (genvar l = 0; l <= LV; l++) begin : lvl
    localparam int W = lvl_w(IN_W, OUT_W, l);
    localparam int C = lvl_cnt(N, l);
    logic [C*W-1:0] q;

    if (l == 0) begin : g_in
      assign q = in_data;
    end else begin : g_reg
      localparam int WP = lvl_w(IN_W, OUT_W, l - 1);
      localparam int CP = lvl_cnt(N, l - 1);
      logic [C*W-1:0] d;
      logic           en;

      if (l == 1) begin : g_en0
        assign en = in_valid;
      end else begin : g_enl
        assign en = vld_pipe[l-1];
      end

      for (genvar j = 0; j < C; j++) begin : node
        logic [WP-1:0] sa;
        logic [W-1:0]  a;
        assign sa = lvl[l-1].q[2*j*WP +: WP];
        // the extra top bit is the fill bit: sign when signed, zero otherwise
        assign a  = W'($signed({SIGNED_EN & sa[WP-1], sa}));
        if (2 * j + 1 < CP) begin : g_pair
          logic [WP-1:0] sb;
          logic [W-1:0]  b;
          assign sb = lvl[l-1].q[(2*j+1)*WP +: WP];
          assign b  = W'($signed({SIGNED_EN & sb[WP-1], sb}));
          assign d[j*W +: W] = a + b;
        end else begin : g_pass
          assign d[j*W +: W] = a;
        end
      end

      // level register; holds through bubbles so the output stays stable
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
      end
    end
  end

  assign out_valid = vld_pipe[LV];
  assign out_data  = OUT_W'($signed({SIGNED_EN & lvl[LV].q[WL-1], lvl[LV].q}));

endmodule

// File: rtl/conv_kxk_pipe.sv
// conv_kxk_pipe: K x K convolution window engine with a serially loaded kernel.
// Products are registered at window acceptance, then reduced by
// conv_adder_tree_pipe. Latency 1 + clog2(K*K). Build option CONV_SIGNED_EN
// selects two's complement arithmetic (see conv_pkg).
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int OUT_W  = out_w_default(DATA_W, K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kload_valid,
  input  logic [DATA_W-1:0]     kload_data,
  output logic                  kload_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K*K*DATA_W-1:0] in_data,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic                  kernel_ok
);
  localparam int N  = K * K;
  localparam int PW = 2 * DATA_W;
  localparam int IW = clog2(N);

  conv_state_t              state;
  logic [IW-1:0]            idx;
  logic [N-1:0][DATA_W-1:0] coef;
  logic [N-1:0][PW-1:0]     prod_c;
  logic [N-1:0][PW-1:0]     prod_q;
  logic                     prod_vld;
  logic                     accept;

  // a reload strobe in RUN takes priority over a window in the same cycle
  assign in_ready = (state == RUN) && !kload_valid;
  assign accept   = in_valid && in_ready;

  // kernel load sequencer: EMPTY -> LOADING -> RUN, any strobe in RUN restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      idx        <= '0;
      coef       <= '0;
      kload_done <= 1'b0;
      kernel_ok  <= 1'b0;
    end else begin
      kload_done <= 1'b0;
      case (state)
        EMPTY: begin
          if (kload_valid) begin
            coef[0] <= kload_data;
            idx     <= IW'(1);
            state   <= LOADING;
          end
        end
        LOADING: begin
          if (kload_valid) begin
            coef[idx] <= kload_data;
            if (idx == IW'(N - 1)) begin
              idx        <= '0;
              kload_done <= 1'b1;
              kernel_ok  <= 1'b1;
              state      <= RUN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        RUN: begin
          if (kload_valid) begin
            coef[0]   <= kload_data;
            idx       <= IW'(1);
            kernel_ok <= 1'b0;
            state     <= LOADING;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // per-tap multipliers; operands extended to 2*DATA_W so the low half of
  // the product is exact for both signed and unsigned builds
  for (genvar i = 0; i < N; i++) begin : g_tap
    logic [DATA_W-1:0] px, cf;
    logic [PW-1:0]     pxe, cfe;
    assign px        = in_data[i*DATA_W +: DATA_W];
    assign cf        = coef[i];
    assign pxe       = PW'($signed({SIGNED_EN & px[DATA_W-1], px}));
    assign cfe       = PW'($signed({SIGNED_EN & cf[DATA_W-1], cf}));
    assign prod_c[i] = pxe * cfe;
  end

  // product stage: captures the window against the kernel live at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) prod_q <= prod_c;
    end
  end

  conv_adder_tree_pipe #(
    .N     (N),
    .IN_W  (PW),
    .OUT_W (OUT_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (prod_vld),
    .in_data   (prod_q),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// tb_conv_kxk_pipe: self-checking bench for conv_kxk_pipe (K=5 main instance,
// K=3 side instance). Honours CONV_SIGNED_EN in its reference model.
module tb_conv_kxk_pipe;
  localparam int L = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         kload_valid, kload_done, in_valid, in_ready, out_valid, kernel_ok;
  logic [7:0]   kload_data;
  logic [199:0] in_data;
  logic [20:0]  out_data;

  logic         kv3, kd3_done, iv3, ir3, ov3, ok3;
  logic [7:0]   kd3;
  logic [71:0]  id3;
  logic [19:0]  od3;

  conv_kxk_pipe #(.DATA_W(8), .K(5)) dut (
    .clk(clk), .rst(rst), .kload_valid(kload_valid), .kload_data(kload_data),
    .kload_done(kload_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .kernel_ok(kernel_ok));

  conv_kxk_pipe #(.DATA_W(8), .K(3)) dut3 (
    .clk(clk), .rst(rst), .kload_valid(kv3), .kload_data(kd3),
    .kload_done(kd3_done), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_data(od3), .kernel_ok(ok3));

  always #5 clk = ~clk;

  typedef struct { logic [20:0] exp; int due; } sb_t;
  typedef struct { logic [7:0] c; logic [7:0] p; logic [20:0] exp; } vec_t;

  sb_t        sbq[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, kdone_cnt = 0, n_out = 0;
  logic [20:0] last_out;
  logic [7:0] kern_cur [25];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint tv(input logic [7:0] v);
`ifdef CONV_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // reference: plain dot product of kernel and window, wrapped to 21 bits
  function automatic logic [20:0] model(input logic [7:0] k [25], input logic [199:0] w);
    longint s;
    s = 0;
    for (int i = 0; i < 25; i++) s += tv(k[i]) * tv(w[i*8 +: 8]);
    return s[20:0];
  endfunction

  function automatic logic [199:0] rand_win();
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  // output monitor: every out_valid must match the next expected result, on time
  always @(negedge clk) begin
    sb_t e;
    if (kload_done) kdone_cnt++;
    if (out_valid) begin
      n_out++;
      last_out = out_data;
      if (sbq.size() == 0) chk("unexpected out_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.exp);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic step(input logic v, input logic [199:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    #1;
    if (v && in_ready) sbq.push_back('{model(kern_cur, d), cyc + L});
  endtask

  task automatic load_kernel(input logic [7:0] k [25]);
    int bad;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      kload_valid = 1'b1;
      kload_data  = k[i];
      #1;
      if (in_ready) bad++;
    end
    @(negedge clk);
    kload_valid = 1'b0;
    in_valid    = 1'b0;
    #1;
    chk("in_ready during load", bad, 0);
    chk("kload_done after load", kload_done, 1);
    chk("in_ready after load", in_ready, 1);
    chk("kernel_ok after load", kernel_ok, 1);
    kern_cur = k;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tab [6];
    logic [7:0]   kk [25];
    logic [7:0]   k2 [25];
    logic [19:0]  e3;
    int           n0, bad, lat;
    logic         got;

`ifdef CONV_SIGNED_EN
    tab[0] = '{8'd255, 8'd255, 21'd25};
    tab[1] = '{8'd0,   8'd200, 21'd0};
    tab[2] = '{8'd2,   8'd3,   21'd150};
    tab[3] = '{8'd255, 8'd1,   21'(-25)};
    tab[4] = '{8'd128, 8'd128, 21'd409600};
    tab[5] = '{8'd127, 8'd255, 21'(-3175)};
    e3     = 20'(-1143);
`else
    tab[0] = '{8'd255, 8'd255, 21'd1625625};
    tab[1] = '{8'd0,   8'd200, 21'd0};
    tab[2] = '{8'd2,   8'd3,   21'd150};
    tab[3] = '{8'd255, 8'd1,   21'd6375};
    tab[4] = '{8'd128, 8'd128, 21'd409600};
    tab[5] = '{8'd127, 8'd255, 21'd809625};
    e3     = 20'd291465;
`endif

    rst = 1'b1; kload_valid = 0; kload_data = 0; in_valid = 0; in_data = '0;
    kv3 = 0; kd3 = 0; iv3 = 0; id3 = '0;
    for (int i = 0; i < 25; i++) kern_cur[i] = 8'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset kload_done", kload_done, 0);
    chk("reset kernel_ok", kernel_ok, 0);
    rst = 1'b0;

    // kernel 1..25 against an all-ones window
    for (int i = 0; i < 25; i++) kk[i] = 8'(i + 1);
    load_kernel(kk);
    step(1'b1, {25{8'd1}});
    step(1'b0, '0);
    wait_drain();
    chk("ramp kernel sum", last_out, 21'd325);
    repeat (3) @(negedge clk);
    chk("kload_done pulse count", kdone_cnt, 1);

    // uniform kernel/window table
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 25; i++) kk[i] = tab[t].c;
      load_kernel(kk);
      step(1'b1, {25{tab[t].p}});
      step(1'b0, '0);
      wait_drain();
      chk($sformatf("table[%0d]", t), last_out, tab[t].exp);
    end

    // 100 back-to-back random windows on a random kernel
    for (int i = 0; i < 25; i++) kk[i] = 8'($urandom);
    load_kernel(kk);
    n0 = n_out;
    for (int w = 0; w < 100; w++) step(1'b1, rand_win());
    step(1'b0, '0);
    wait_drain();
    chk("burst output count", n_out - n0, 100);

    // reload while 5 windows are in flight; a window is held on the bus
    for (int i = 0; i < 25; i++) kk[i] = 8'($urandom);
    load_kernel(kk);
    n0 = n_out;
    for (int w = 0; w < 5; w++) step(1'b1, rand_win());
    for (int i = 0; i < 25; i++) k2[i] = 8'($urandom);
    load_kernel(k2);
    wait_drain();
    chk("in-flight results", n_out - n0, 5);
    step(1'b1, rand_win());
    step(1'b0, '0);
    wait_drain();

    // reset two cycles after an accepted window
    n0 = n_out;
    step(1'b1, rand_win());
    step(1'b0, '0);
    step(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset kernel_ok", kernel_ok, 0);
    chk("mid reset in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rand_win();
      #1;
      if (in_ready) bad++;
    end
    in_valid = 1'b0;
    chk("no out_valid after reset", n_out - n0, 0);
    chk("in_ready low after reset", bad, 0);
    for (int i = 0; i < 25; i++) kk[i] = 8'($urandom);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      kload_valid = 1'b1;
      kload_data  = kk[i];
    end
    @(negedge clk);
    kload_valid = 1'b0;
    #1;
    chk("partial load in_ready", in_ready, 0);
    chk("partial load kernel_ok", kernel_ok, 0);
    @(negedge clk);
    kload_valid = 1'b1;
    kload_data  = kk[24];
    @(negedge clk);
    kload_valid = 1'b0;
    #1;
    chk("fresh load in_ready", in_ready, 1);
    chk("fresh load kernel_ok", kernel_ok, 1);
    kern_cur = kk;
    step(1'b1, rand_win());
    step(1'b0, '0);
    wait_drain();

    // K=3 instance: kernel of 0xFF, window of 127, latency 5
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      kv3 = 1'b1;
      kd3 = 8'hFF;
    end
    @(negedge clk);
    kv3 = 1'b0;
    #1;
    chk("k3 kload_done", kd3_done, 1);
    chk("k3 in_ready", ir3, 1);
    chk("k3 kernel_ok", ok3, 1);
    @(negedge clk);
    iv3 = 1'b1;
    id3 = {9{8'd127}};
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      iv3 = 1'b0;
      if (ov3) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("k3 latency", lat, 5);
    chk("k3 out_data", od3, e3);
    @(negedge clk);
    chk("k3 single pulse", ov3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
